// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 divider: one restoring-division quotient bit per clock, RNE rounding.
// Optional macro FP_DIV_SEQ_EARLY_OUT_EN lets special operands skip ITER/ROUND.
module fp_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     opd1,
    input  logic [EXP_W+MAN_W:0]     opd2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     res,
    output logic                     overflow
);

    localparam int W      = EXP_W + MAN_W + 1;
    localparam int Q_BITS = MAN_W + 2;
    localparam int CNT_W  = $clog2(Q_BITS);
    localparam int E_W    = EXP_W + 2;
    localparam logic signed [E_W-1:0] BIAS    = E_W'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [E_W-1:0] EXP_MAX = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] E_ZERO  = '0;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, ITER, ROUND, DONE} state_t;

    state_t                  state_q, state_d;
    logic [W-1:0]            a_q, a_d, b_q, b_d;
    logic                    sign_q, sign_d;
    logic signed [E_W-1:0]   exp_q, exp_d;
    logic [MAN_W+1:0]        rem_q, rem_d;
    logic [MAN_W:0]          div_q, div_d;
    logic [Q_BITS-1:0]       quo_q, quo_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    special_q, special_d;
    logic [W-1:0]            spec_res_q, spec_res_d;
    logic [W-1:0]            res_q, res_d;
    logic                    ovf_q, ovf_d;

    logic [EXP_W-1:0]        e1, e2;
    logic [MAN_W-1:0]        f1, f2;
    logic                    zero1, zero2, inf1, inf2, nan1, nan2, sgn;
    logic [MAN_W:0]          m1, m2;
    logic signed [E_W-1:0]   e_unp;
    logic                    is_special;
    logic [W-1:0]            special_val;
    logic                    rnd_up;
    logic [MAN_W+1:0]        mant_r;
    logic [MAN_W-1:0]        frac_r;
    logic signed [E_W-1:0]   e_rnd;
    logic [MAN_W+1:0]        rem_sub;
    logic                    q_bit;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign res       = res_q;
    assign overflow  = ovf_q;

    // Operand classification; subnormals collapse to signed zero
    always_comb begin
        e1    = a_q[W-2:MAN_W];
        e2    = b_q[W-2:MAN_W];
        f1    = a_q[MAN_W-1:0];
        f2    = b_q[MAN_W-1:0];
        sgn   = a_q[W-1] ^ b_q[W-1];
        zero1 = (e1 == '0);
        zero2 = (e2 == '0);
        inf1  = (&e1) && (f1 == '0);
        inf2  = (&e2) && (f2 == '0);
        nan1  = (&e1) && (f1 != '0);
        nan2  = (&e2) && (f2 != '0);
        m1    = {1'b1, f1};
        m2    = {1'b1, f2};
        e_unp = $signed({2'b00, e1}) - $signed({2'b00, e2}) + BIAS;

        is_special  = 1'b1;
        special_val = {sgn, {(W-1){1'b0}}};
        if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2))
            special_val = QNAN;
        else if (zero2 || inf1)
            special_val = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (!(inf2 || zero1))
            is_special = 1'b0;
    end

    // One restoring step and the final round/pack
    always_comb begin
        q_bit   = (rem_q >= {1'b0, div_q});
        rem_sub = q_bit ? (rem_q - {1'b0, div_q}) : rem_q;

        rnd_up = quo_q[0] & ((rem_q != '0) | quo_q[1]);
        mant_r = {1'b0, quo_q[Q_BITS-1:1]} + (MAN_W+2)'(rnd_up);
        if (mant_r[MAN_W+1]) begin
            frac_r = '0;
            e_rnd  = exp_q + E_W'(1);
        end else begin
            frac_r = mant_r[MAN_W-1:0];
            e_rnd  = exp_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        rem_d      = rem_q;
        div_d      = div_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        res_d      = res_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = opd1;
                    b_d     = opd2;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                sign_d     = sgn;
                div_d      = m2;
                quo_d      = '0;
                cnt_d      = '0;
                special_d  = is_special;
                spec_res_d = special_val;
                // Pre-scale the dividend so the quotient lands in [1,2)
                if (m1 < m2) begin
                    rem_d = {m1, 1'b0};
                    exp_d = e_unp - E_W'(1);
                end else begin
                    rem_d = {1'b0, m1};
                    exp_d = e_unp;
                end
`ifdef FP_DIV_SEQ_EARLY_OUT_EN
                if (is_special) begin
                    res_d   = special_val;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = ITER;
                end
`else
                state_d = ITER;
`endif
            end
            ITER: begin
                rem_d = rem_sub << 1;
                quo_d = {quo_q[Q_BITS-2:0], q_bit};
                if (cnt_q == CNT_W'(Q_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ROUND: begin
                ovf_d = 1'b0;
                if (special_q)
                    res_d = spec_res_q;
                else if (e_rnd >= EXP_MAX) begin
                    res_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    ovf_d = 1'b1;
                end else if (e_rnd <= E_ZERO)
                    res_d = {sign_q, {(W-1){1'b0}}};
                else
                    res_d = {sign_q, e_rnd[EXP_W-1:0], frac_r};
                state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            rem_q      <= '0;
            div_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            rem_q      <= rem_d;
            div_q      <= div_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            res_q      <= res_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Randomised and directed bench for fp_div_seq (default binary32 build) against an integer-arithmetic model.
module tb_fp_div_seq;

    localparam int LAT = 27;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] opd1 = '0;
    logic [31:0] opd2 = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] res;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    fp_div_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opd1(opd1), .opd2(opd2),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Exact quotient via wide integer division, then RNE; returns {overflow, res}
    function automatic logic [32:0] refDiv(input logic [31:0] a, input logic [31:0] b);
        logic s;
        logic [7:0] ea, eb;
        logic [22:0] fa, fb;
        longint ma, mb, num, q, r, mant;
        int e;
        logic g, st;
        s  = a[31] ^ b[31];
        ea = a[30:23]; fa = a[22:0];
        eb = b[30:23]; fb = b[22:0];
        if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0) ||
            (ea == 0 && eb == 0) || (ea == 8'hFF && eb == 8'hFF))
            return {1'b0, 32'h7FC00000};
        if (eb == 0 || ea == 8'hFF) return {1'b0, s, 8'hFF, 23'h0};
        if (eb == 8'hFF || ea == 0) return {1'b0, s, 31'h0};
        ma  = longint'({1'b1, fa});
        mb  = longint'({1'b1, fb});
        e   = int'(ea) - int'(eb) + 127;
        num = ma << 26;
        q   = num / mb;
        r   = num % mb;
        if (q >= (longint'(1) << 26)) begin
            mant = q >> 3;
            g    = q[2];
            st   = (q[1:0] != 0) || (r != 0);
        end else begin
            mant = q >> 2;
            g    = q[1];
            st   = q[0] || (r != 0);
            e    = e - 1;
        end
        if (g && (st || mant[0])) mant = mant + 1;
        if (mant == (longint'(1) << 24)) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
        if (e <= 0)   return {1'b0, s, 31'h0};
        return {1'b0, s, 8'(e), mant[22:0]};
    endfunction

    function automatic logic [31:0] randOp();
        int cls;
        logic s;
        logic [22:0] f;
        cls = int'($urandom_range(0, 19));
        s   = 1'($urandom);
        f   = 23'($urandom);
        case (cls)
            0:       return {s, 8'h00, f};
            1:       return {s, 8'hFF, 23'h0};
            2:       return {s, 8'hFF, f | 23'h1};
            3, 4:    return {s, 8'($urandom_range(1, 254)), f};
            default: return {s, 8'($urandom_range(110, 144)), f};
        endcase
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [32:0] want;
        int edges;
        want = refDiv(a, b);
        @(negedge clk);
        checkOutput("idle_in_ready", 64'(in_ready), 64'd1);
        opd1     = a;
        opd2     = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        opd1     = $urandom;
        opd2     = $urandom;
        checkOutput("busy_in_ready", 64'(in_ready), 64'd0);
        edges = 0;
        while (!out_valid && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        checkOutput("latency", 64'(edges), 64'(LAT));
        checkOutput("res", 64'(res), 64'(want[31:0]));
        checkOutput("ovf", 64'(overflow), 64'(want[32]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_res", 64'(res), 64'(want[31:0]));
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("ack_valid", 64'(out_valid), 64'd0);
        checkOutput("ack_in_ready", 64'(in_ready), 64'd1);
        checkOutput("ack_res", 64'(res), 64'(want[31:0]));
    endtask

    initial begin
        #7;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_res", 64'(res), 64'd0);
        checkOutput("rst_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'h40C00000, 32'h40000000, 0);
        applyStimulus(32'h3F800000, 32'h40400000, 5);
        applyStimulus(32'hBFC00000, 32'h3F000000, 1);
        applyStimulus(32'h7F000000, 32'h00800000, 0);
        applyStimulus(32'h00800000, 32'h7F000000, 0);
        applyStimulus(32'h3F800000, 32'h00000000, 0);
        applyStimulus(32'h00000000, 32'h00000000, 0);
        applyStimulus(32'h7FC00001, 32'h3F800000, 2);
        applyStimulus(32'hFF800000, 32'h40000000, 0);
        applyStimulus(32'h3F800000, 32'h7F800000, 0);

        for (int n = 0; n < 40; n++)
            applyStimulus(randOp(), randOp(), int'($urandom_range(0, 2)));

        @(negedge clk);
        opd1     = 32'h40C00000;
        opd2     = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_res", 64'(res), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_abort_valid", 64'(out_valid), 64'd0);
        applyStimulus(32'h40C00000, 32'h40000000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
